// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// Optional feature macro: WB_ARB_RR_EN (round-robin arbitration when defined).
// The slicing macros are used by every block that handles flattened
// per-requester buses.
`ifndef REGFILE_WB_ARBITER_PKG_SV
`define REGFILE_WB_ARBITER_PKG_SV

`define WB_SLICE(bus, i, w)    bus[(i)*(w) +: (w)]
`define WB_ADDR_SLICE(bus, i)  `WB_SLICE(bus, i, regfile_wb_arbiter_pkg::REG_ADDR_W)
`define WB_DATA_SLICE(bus, i)  `WB_SLICE(bus, i, regfile_wb_arbiter_pkg::XLEN)

package regfile_wb_arbiter_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // Index width for a requester count; never narrower than one bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

`endif

// File: rtl/regfile_wb_arbiter_if.sv
// Requester bus plus register-file write port of the write-back arbiter.
// Parameters must match those of the regfile_wb_arbiter instance bound to it.
interface regfile_wb_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int CNT_W   = 16
);
   import regfile_wb_arbiter_pkg::*;

   logic [NUM_REQ-1:0]            req_valid;
   logic [REG_ADDR_W*NUM_REQ-1:0] req_addr;
   logic [XLEN*NUM_REQ-1:0]       req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          we3;
   logic [REG_ADDR_W-1:0]         a3;
   logic [XLEN-1:0]               wd3;
   logic                          wb_busy;
   logic [CNT_W-1:0]              stall_cnt;

   // Write-back sources side
   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, we3, a3, wd3, wb_busy, stall_cnt
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, we3, a3, wd3, wb_busy, stall_cnt
   );
endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// wb_rr_arbiter: combinational rotating-priority picker. Search starts at
// ptr_i+1 (mod NUM_REQ); driving ptr_i with NUM_REQ-1 gives fixed priority
// with index 0 highest.
module wb_rr_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = ptr_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0]   idx_o
);

   int               cand;
   logic [PTR_W-1:0] cidx;
   logic             found;

   // Walk requesters from ptr_i+1 around the ring; first valid one wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = 0;
      cidx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(ptr_i) + k) % NUM_REQ;
         cidx = PTR_W'(cand);
         if (!found && req_i[cidx]) begin
            found       = 1'b1;
            gnt_o[cidx] = 1'b1;
            idx_o       = cidx;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port among NUM_REQ
// write-back sources, one write per cycle, registered output stage.
// Optional feature macro: WB_ARB_RR_EN -- round-robin with a last-grant
// pointer when defined, fixed lowest-index-first priority otherwise.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int CNT_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   regfile_wb_arbiter_if.slave bus
);

   localparam int PTR_W = ptr_w(NUM_REQ);

   logic [NUM_REQ-1:0]    gnt;
   logic [PTR_W-1:0]      gnt_idx;
   logic [PTR_W-1:0]      arb_ptr;
   logic                  xfer;
   logic                  waiting;

   logic                  out_v_q, out_v_d;
   logic [REG_ADDR_W-1:0] a3_q, a3_d;
   logic [XLEN-1:0]       wd3_q, wd3_d;
   logic [CNT_W-1:0]      stall_q, stall_d;

`ifdef WB_ARB_RR_EN
   logic [PTR_W-1:0]      last_gnt_q, last_gnt_d;

   assign arb_ptr = last_gnt_q;

   // Pointer moves only when a beat is actually taken.
   always_comb begin
      last_gnt_d = last_gnt_q;
      if (xfer) last_gnt_d = gnt_idx;
   end

   // Pointer register; reset value makes requester 0 first in line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_gnt_q <= PTR_W'(NUM_REQ - 1);
      else        last_gnt_q <= last_gnt_d;
   end
`else
   // Constant pointer turns the rotating search into lowest-index-first.
   assign arb_ptr = PTR_W'(NUM_REQ - 1);
`endif

   wb_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req_i (bus.req_valid),
      .ptr_i (arb_ptr),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   // Output stage never stalls, so the grant is the ready.
   assign bus.req_ready = gnt;
   assign xfer          = |gnt;
   assign waiting       = |(bus.req_valid & ~gnt);

   // Capture the granted beat; address/data hold when idle to avoid toggling.
   always_comb begin
      out_v_d = xfer;
      a3_d    = a3_q;
      wd3_d   = wd3_q;
      if (xfer) begin
         a3_d  = `WB_ADDR_SLICE(bus.req_addr, int'(gnt_idx));
         wd3_d = `WB_DATA_SLICE(bus.req_data, int'(gnt_idx));
      end
   end

   // Contention counter: count cycles with a waiting requester, stick at max.
   always_comb begin
      stall_d = stall_q;
      if (waiting && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
   end

   // Output stage and counter; reset discards any beat in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_v_q <= 1'b0;
         a3_q    <= REG_ZERO;
         wd3_q   <= '0;
         stall_q <= '0;
      end else begin
         out_v_q <= out_v_d;
         a3_q    <= a3_d;
         wd3_q   <= wd3_d;
         stall_q <= stall_d;
      end
   end

   // x0 beats occupy the stage but never write the register file.
   assign bus.we3       = out_v_q && (a3_q != REG_ZERO);
   assign bus.a3        = a3_q;
   assign bus.wd3       = wd3_q;
   assign bus.wb_busy   = out_v_q;
   assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: the driver pushes the expected
// write-port beat for every hand-predicted grant, the monitor pops and
// compares whenever the output stage reports a beat.
module tb_regfile_wb_arbiter;
   localparam int NR = 3;
   localparam int CW = 4;
`ifdef WB_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct packed {
      logic        we3;
      logic [4:0]  a3;
      logic [31:0] wd3;
   } wb_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.NUM_REQ(NR), .CNT_W(CW)) bus ();
   regfile_wb_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [4:0]    addr [NR];
   logic [31:0]   data [NR];
   logic [NR-1:0] pend;
   wb_t           exp_q [$];
   int            checks   = 0;
   int            failures = 0;

   for (genvar g = 0; g < NR; g++) begin : g_drv
      assign bus.req_addr[g*5 +: 5]   = addr[g];
      assign bus.req_data[g*32 +: 32] = data[g];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every beat the output stage presents must match the queue head.
   always @(negedge clk) begin
      wb_t e;
      if (bus.wb_busy === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(bus.a3), 64'hFFFF);
         end else begin
            e = exp_q.pop_front();
            chk("beat_we3", 64'(bus.we3), 64'(e.we3));
            chk("beat_a3",  64'(bus.a3),  64'(e.a3));
            chk("beat_wd3", 64'(bus.wd3), 64'(e.wd3));
         end
      end else if (rst_n) begin
         chk("idle_we3", 64'(bus.we3), 64'd0);
      end
   end

   // One cycle of stimulus: apply valids, check grant, predict the beat.
   task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] exp_rdy, input string tag);
      chk({tag, "_protocol"}, 64'(pend & ~v), 64'd0);
      bus.req_valid = v;
      @(negedge clk);
      chk({tag, "_ready"}, 64'(bus.req_ready), 64'(exp_rdy));
      @(posedge clk);
      for (int i = 0; i < NR; i++)
         if (exp_rdy[i]) exp_q.push_back('{we3: (addr[i] != 5'd0), a3: addr[i], wd3: data[i]});
      pend = v & ~exp_rdy;
      #1;
   endtask

   task automatic do_reset();
      bus.req_valid = '0;
      @(negedge clk);
      chk("drained", 64'(exp_q.size()), 64'd0);
      rst_n = 1'b0;
      exp_q.delete();
      pend = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic [NR-1:0] e;
      bus.req_valid = '0;
      pend = '0;
      for (int i = 0; i < NR; i++) begin addr[i] = '0; data[i] = '0; end

      // Reset state
      #2;
      chk("rst_we3",   64'(bus.we3),       64'd0);
      chk("rst_a3",    64'(bus.a3),        64'd0);
      chk("rst_wd3",   64'(bus.wd3),       64'd0);
      chk("rst_busy",  64'(bus.wb_busy),   64'd0);
      chk("rst_stall", 64'(bus.stall_cnt), 64'd0);
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single write from requester 1
      addr[1] = 5'd5; data[1] = 32'hDEADBEEF;
      step(3'b010, 3'b010, "single");
      step(3'b000, 3'b000, "single_idle");
      chk("stall_single", 64'(bus.stall_cnt), 64'd0);

      // Single requester streaming: one beat per cycle, no bubbles
      for (int k = 0; k < 4; k++) begin
         addr[0] = 5'(8 + k); data[0] = 32'h100 + 32'(k);
         step(3'b001, 3'b001, "stream");
      end
      step(3'b000, 3'b000, "stream_idle");

      // x0 write: consumed, busy, but no register-file write
      addr[0] = 5'd0; data[0] = 32'h1;
      step(3'b001, 3'b001, "x0");
      chk("x0_busy", 64'(bus.wb_busy), 64'd1);
      chk("x0_we3",  64'(bus.we3),     64'd0);
      step(3'b000, 3'b000, "x0_idle");

      // Full contention for 6 cycles from a fresh reset
      do_reset();
      addr[0] = 5'd1; data[0] = 32'hA0A0_0000;
      addr[1] = 5'd2; data[1] = 32'hB1B1_1111;
      addr[2] = 5'd3; data[2] = 32'hC2C2_2222;
      for (int k = 0; k < 6; k++) begin
         e = RR ? 3'(1 << (k % 3)) : 3'b001;
         step(3'b111, e, "contend");
      end
      chk("stall_contend", 64'(bus.stall_cnt), 64'd6);
      chk("we3_pre_reset", 64'(bus.we3), 64'd1);

      // Reset mid-stream: in-flight beat lost immediately
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we3",   64'(bus.we3),       64'd0);
      chk("mid_rst_a3",    64'(bus.a3),        64'd0);
      chk("mid_rst_wd3",   64'(bus.wd3),       64'd0);
      chk("mid_rst_busy",  64'(bus.wb_busy),   64'd0);
      chk("mid_rst_stall", 64'(bus.stall_cnt), 64'd0);
      chk("mid_rst_ready", 64'(bus.req_ready), 64'd1);
      exp_q.delete();
      pend = '0;
      bus.req_valid = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Requester 0 wins first contention after reset; then the mode differs
      step(3'b011, 3'b001, "first_after_rst");
      step(3'b011, RR ? 3'b010 : 3'b001, "rotate");
      step(RR ? 3'b001 : 3'b010, RR ? 3'b001 : 3'b010, "rotate_tail");

      // Pointer hold: grant 2, idle 3 cycles, then 0 and 2 -> 0 first
      step(3'b100, 3'b100, "hold_g2");
      for (int k = 0; k < 3; k++) step(3'b000, 3'b000, "hold_idle");
      step(3'b101, 3'b001, "hold_pick");
      step(3'b100, 3'b100, "hold_tail");
      step(3'b000, 3'b000, "hold_done");
      chk("stall_hold", 64'(bus.stall_cnt), 64'd3);

      // Counter saturation with a 4-bit counter
      do_reset();
      for (int k = 0; k < 20; k++) begin
         e = RR ? 3'(1 << (k % 3)) : 3'b001;
         step(3'b111, e, "sat");
         if (k == 9)  chk("stall_sat_10", 64'(bus.stall_cnt), 64'd10);
         if (k == 15) chk("stall_sat_16", 64'(bus.stall_cnt), 64'hF);
      end
      chk("stall_sat_end", 64'(bus.stall_cnt), 64'hF);
      bus.req_valid = '0;
      pend = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
